seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display, sitting downstream of the BCD counter. Consumes the counter's 16-bit packed BCD value and its `flash_slow`/`flash_fast` indicators, and scans one digit at a time. Each digit slot has a dead-time blank interval to suppress ghosting. The block adds per-frame snapshotting (no tearing), leading-zero suppression, flash blanking and invalid-nibble indication.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `LZ_SUPPRESS`, 1: 1 = blank leading zero digits 3..1; 0 = show all digits.
- `DP_MASK`, 4'b0000: bit i = 1 lights the decimal point on digit i.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `bcd_value` input 16: packed BCD; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `flash_slow` input 1: when high, display is blanked.
- `flash_fast` input 1: when high, display is blanked.
- `an` output 4: anode enables, active-low, one-hot-low while driving.
- `seg` output 7: {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `frame_tick` output 1: one-cycle pulse when a new snapshot is taken.

## Operation
- State: `digit_idx` (2 bits, counts 0→1→2→3→0); `slot_cnt` (counts 0..`SCAN_DIV`-1); phase BLANK or DRIVE; 16-bit `snap`.
- Phase rules:
  - BLANK while `slot_cnt` < `BLANK_CYCLES`; DRIVE otherwise.
  - When `slot_cnt` reaches `SCAN_DIV`-1, it wraps to 0 and `digit_idx` increments, wrapping 3→0.
- Snapshot: on the cycle where `slot_cnt`==0 and `digit_idx`==0, `snap` ← `bcd_value` and `frame_tick`=1. This includes the first cycle after reset deasserts. `bcd_value` changes mid-frame are not displayed until the next frame.
- Digit nibble: n = `snap`[4·`digit_idx`+3 : 4·`digit_idx`].
- Decode, active-low:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - 10–15 = dash 0x3F (segment g only).
- Leading-zero suppression (`LZ_SUPPRESS`=1):
  - Digit k (k=3,2,1) is suppressed if `snap` nibbles k..3 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit drives `an`=4'b1111, `seg`=0x7F, `dp`=1.
- Flash blanking: if `flash_slow` | `flash_fast` is high in a given cycle, that cycle drives the blank pattern. Flash inputs are sampled every cycle, not snapshotted.
- DRIVE pattern (not blanked or suppressed):
  - `an` = ~(4'b0001 << `digit_idx`)
  - `seg` = decode(n)
  - `dp` = ~`DP_MASK`[`digit_idx`]
- BLANK pattern: `an`=4'b1111, `seg`=0x7F, `dp`=1.
- Invariant: at most one `an` bit is low in any cycle.

## Timing
- All outputs are registered. They reflect the state and inputs of the previous cycle, so latency from `flash_*` to outputs is 1 cycle.
- Reset (any cycle, including mid-slot), on the next edge:
  - `an`=4'b1111, `seg`=0x7F, `dp`=1, `frame_tick`=0
  - `digit_idx`=0, `slot_cnt`=0, `snap`=0
- First cycle after reset deasserts: snapshot is taken. Outputs then show blank for `BLANK_CYCLES` cycles, then digit 0 for `SCAN_DIV`-`BLANK_CYCLES` cycles.
- Frame period is 4·`SCAN_DIV` cycles. `frame_tick` pulses exactly once per frame and is high for 1 cycle.
- Slot boundary: the last DRIVE cycle of digit i is immediately followed by the first BLANK cycle of digit i+1. Two different anodes are never low in adjacent cycles.
- Flash and suppression gate DRIVE cycles only. BLANK cycles are unaffected.

## Test plan
Bench parameters: `SCAN_DIV`=8, `BLANK_CYCLES`=2.
- Reset / first frame: hold `reset` high 3 cycles, then release with `bcd_value`=0x1234 and flash inputs low.
  - Expect reset values; one `frame_tick` on the first released cycle.
  - Then per slot: 2 cycles `an`=1111, then 6 cycles at `an` = 1110/1101/1011/0111 with `seg` = 0x19 / 0x30 / 0x24 / 0x79.
- Leading zeros: `bcd_value`=0x0070 with `LZ_SUPPRESS`=1.
  - Digit 0 shows 0x40 and digit 1 shows 0x78.
  - Digits 2 and 3 stay `an`=1111 for the whole slot.
  - Repeat with `LZ_SUPPRESS`=0: digits 2 and 3 show 0x40.
- Tearing: change `bcd_value` from 0x1111 to 0x2222 while digit 1 is driving.
  - Digits 1–3 still show 0x79 in that frame.
  - Next frame shows 0x24 on every digit, starting at digit 0.
- Flash: toggle `flash_fast` high for 3 cycles mid-DRIVE, and separately hold `flash_slow` high for a full frame.
  - Blank pattern appears exactly 1 cycle after each high cycle.
  - Normal drive resumes 1 cycle after release.
- Invalid nibble and DP: `bcd_value`=0xA0F5, `DP_MASK`=4'b0100.
  - Digit 0: 0x12, `dp`=1.
  - Digit 1: dash 0x3F.
  - Digit 2: 0x40 with `dp`=0.
  - Digit 3: dash.
- Reset mid-slot: assert `reset` during the DRIVE of digit 2.
  - Next edge gives reset values.
  - After release, the scan restarts at digit 0 with a fresh snapshot; the one-hot anode invariant holds throughout.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit common-anode seven-segment scanner
// Ports: clk, reset (sync, active-high); bcd_value[15:0] packed BCD, digit 0 in [3:0];
//        flash_slow/flash_fast blank the display while high;
//        an[3:0] active-low anodes, seg[6:0] {g..a} active-low, dp active-low;
//        frame_tick pulses for one cycle whenever a new snapshot of bcd_value is taken.
module seg7_scan_driver #(
    parameter int         SCAN_DIV     = 50000,
    parameter int         BLANK_CYCLES = 500,
    parameter bit         LZ_SUPPRESS  = 1'b1,
    parameter logic [3:0] DP_MASK      = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_value,
    input  logic        flash_slow,
    input  logic        flash_fast,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);
    typedef enum logic {BLANK, DRIVE} phase_t;
    phase_t        phase;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   snap;
    logic [3:0]    nib;
    logic [3:0]    sup;
    logic [6:0]    dec;
    logic          last, start, show;
    always_comb begin
        phase = (slot_cnt < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
        last  = slot_cnt == CW'(SCAN_DIV - 1);
        start = (slot_cnt == '0) && (digit_idx == 2'd0);
        nib   = snap[{digit_idx, 2'b00} +: 4];
        // digit k is a leading zero when it and every digit above it are zero
        sup[3] = LZ_SUPPRESS && (snap[15:12] == 4'd0);
        sup[2] = sup[3] && (snap[11:8] == 4'd0);
        sup[1] = sup[2] && (snap[7:4] == 4'd0);
        sup[0] = 1'b0;
        show  = (phase == DRIVE) && !(flash_slow || flash_fast) && !sup[digit_idx];
        case (nib)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h3F;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx  <= 2'd0;
            slot_cnt   <= '0;
            snap       <= 16'h0000;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (start) snap <= bcd_value;
            frame_tick <= start;
            an         <= show ? ~(4'b0001 << digit_idx) : 4'hF;
            seg        <= show ? dec : 7'h7F;
            dp         <= show ? ~DP_MASK[digit_idx] : 1'b1;
            slot_cnt   <= last ? '0 : slot_cnt + 1'b1;
            if (last) digit_idx <= digit_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2
module tb_seg7_scan_driver;
    localparam int SD = 8;
    localparam int BC = 2;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_value;
    logic        flash_slow, flash_fast;
    logic [3:0]  an, an_nolz;
    logic [6:0]  seg, seg_nolz;
    logic        dp, dp_nolz, frame_tick, frame_tick_nolz;
    always #5 clk = ~clk;
    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b1), .DP_MASK(4'b0100)) u_dut (
        .clk(clk), .reset(reset), .bcd_value(bcd_value), .flash_slow(flash_slow), .flash_fast(flash_fast),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );
    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b0), .DP_MASK(4'b0000)) u_nolz (
        .clk(clk), .reset(reset), .bcd_value(bcd_value), .flash_slow(flash_slow), .flash_fast(flash_fast),
        .an(an_nolz), .seg(seg_nolz), .dp(dp_nolz), .frame_tick(frame_tick_nolz)
    );
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       dp0;
    } exp_t;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_cnt = 0;
    logic [15:0] m_snap = 16'h0000;
    logic [3:0]  prev_an = 4'hF;
    string       sec = "init";
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask
    function automatic exp_t model();
        exp_t        e;
        int          dig;
        logic [15:0] upper;
        logic        drive;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, an0: 4'hF, seg0: 7'h7F, dp0: 1'b1};
        if (reset) begin
            m_cnt  = 0;
            m_snap = 16'h0000;
            return e;
        end
        dig  = m_cnt / SD;
        e.ft = (m_cnt == 0);
        if (e.ft) m_snap = bcd_value;
        upper = m_snap >> (4 * dig);
        drive = ((m_cnt % SD) >= BC) && !(flash_slow || flash_fast);
        if (drive) begin
            e.an0  = ~(4'b0001 << dig);
            e.seg0 = seg_tab[upper[3:0]];
            if (dig == 0 || upper != 16'h0000) begin
                e.an  = e.an0;
                e.seg = e.seg0;
                e.dp  = (dig != 2);
            end
        end
        m_cnt = (m_cnt + 1) % (4 * SD);
        return e;
    endfunction
    task automatic step(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            sb.push_back(model());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({sec, ".an"}, 32'(an), 32'(e.an));
            check({sec, ".seg"}, 32'(seg), 32'(e.seg));
            check({sec, ".dp"}, 32'(dp), 32'(e.dp));
            check({sec, ".frame_tick"}, 32'(frame_tick), 32'(e.ft));
            check({sec, ".nolz.an"}, 32'(an_nolz), 32'(e.an0));
            check({sec, ".nolz.seg"}, 32'(seg_nolz), 32'(e.seg0));
            check({sec, ".nolz.dp"}, 32'(dp_nolz), 32'(e.dp0));
            check({sec, ".onehot"}, 32'($countones(~an) <= 1), 32'd1);
            check({sec, ".adjacent"}, 32'((prev_an | an) == 4'hF || prev_an == an), 32'd1);
            prev_an = an;
            @(negedge clk);
        end
    endtask
    initial begin
        reset = 1'b1; bcd_value = 16'h0000; flash_slow = 1'b0; flash_fast = 1'b0;
        @(negedge clk);
        sec = "reset"; step(3);
        reset = 1'b0; bcd_value = 16'h1234;
        sec = "frame1"; step(4 * SD);
        bcd_value = 16'h0070;
        sec = "lz"; step(4 * SD);
        bcd_value = 16'h1111;
        sec = "tear"; step(SD + 4);
        bcd_value = 16'h2222; step(3 * SD - 4);
        sec = "tear_next"; step(4 * SD);
        bcd_value = 16'h1234;
        sec = "flash_fast"; step(SD + 4);
        flash_fast = 1'b1; step(3);
        flash_fast = 1'b0; step(3 * SD - 7);
        flash_slow = 1'b1;
        sec = "flash_slow"; step(4 * SD);
        flash_slow = 1'b0; step(4 * SD);
        bcd_value = 16'hA0F5;
        sec = "invalid_dp"; step(4 * SD);
        bcd_value = 16'h1234;
        sec = "mid_reset"; step(2 * SD + 4);
        reset = 1'b1; step(2);
        reset = 1'b0; bcd_value = 16'h5678;
        sec = "restart"; step(5 * SD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
